// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-through, no-write-allocate data cache. Read hits complete in the request cycle.
// A read miss stalls 1 + WPL*(L+1) cycles. A store stalls until its single memory ack.
module dcache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINES  = 16,
  parameter int WPL    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              cache_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(WPL);
  localparam int TW = ADDR_W - IW - OW - 2;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TW-1:0]      tag_q  [LINES];
  logic [31:0]        data_q [LINES][WPL];
  logic [OW-1:0]      beat_q, beat_d;
  logic               replay_q, replay_d;
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;

  logic [OW-1:0]      off;
  logic [IW-1:0]      idx;
  logic [TW-1:0]      tag;
  logic               hit;
  logic               arr_we, tag_we;
  logic [OW-1:0]      arr_off;
  logic [31:0]        arr_wdat;
  logic               unused_addr_lsb;

  assign off             = addr[OW+1:2];
  assign idx             = addr[IW+OW+1:OW+2];
  assign tag             = addr[ADDR_W-1:IW+OW+2];
  assign unused_addr_lsb = ^addr[1:0];
  assign hit             = valid_q[idx] && (tag_q[idx] == tag);
  assign rdata           = data_q[idx][off];
  assign hit_count       = hit_cnt_q;
  assign miss_count      = miss_cnt_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    beat_d      = beat_q;
    replay_d    = replay_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    cache_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    arr_we      = 1'b0;
    tag_we      = 1'b0;
    arr_off     = off;
    arr_wdat    = wdata;
    case (state_q)
      IDLE: begin
        cache_ready = !req || (!we && hit);
        if (req && we) begin
          state_d = WRITE;
        end else if (req && !hit) begin
          state_d    = REFILL;
          beat_d     = '0;
          miss_cnt_d = miss_cnt_q + 32'd1;
        end else if (req) begin
          // The load replayed after a refill is not a first-look hit.
          if (!replay_q) hit_cnt_d = hit_cnt_q + 32'd1;
          replay_d = 1'b0;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx, beat_q, 2'b00};
        if (mem_ack) begin
          arr_we   = 1'b1;
          arr_off  = beat_q;
          arr_wdat = mem_rdata;
          beat_d   = beat_q + 1'b1;
          if (beat_q == OW'(WPL - 1)) begin
            valid_d[idx] = 1'b1;
            tag_we       = 1'b1;
            replay_d     = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr[ADDR_W-1:2], 2'b00};
        mem_wdata = wdata;
        if (mem_ack) begin
          cache_ready = 1'b1;
          arr_we      = hit;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      beat_q     <= '0;
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
      replay_q   <= replay_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) data_q[idx][arr_off] <= arr_wdat;
    if (tag_we) tag_q[idx] <= tag;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a latency-programmable memory responder.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        cache_ready, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count, miss_count;

  int n_chk = 0;
  int n_bad = 0;
  int lat   = 1;
  int wcnt  = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ack_addr [$];
  logic        ack_we   [$];

  dcache_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .cache_ready(cache_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory: acks a beat after `lat` wait cycles of continuous mem_req.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (wcnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem_word(mem_addr);
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      ack_addr.push_back(mem_addr);
      ack_we.push_back(mem_we);
    end
  end

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; stalls = 0;
    #1;
    while (!cache_ready && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 200) chk("access_timeout", 32'(stalls), 32'd0);
    rd = rdata;
    @(posedge clk);
    #2;
    req = 1'b0;
  endtask

  int          st, base, guard;
  logic [31:0] rd;

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    chk("rst_ready_idle", 32'(cache_ready), 32'd1);
    req = 1'b1;
    #1;
    chk("rst_ready_req", 32'(cache_ready), 32'd0);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Cold miss with one wait cycle per beat.
    base = ack_addr.size();
    access(1'b0, 32'h100, 32'h0, st, rd);
    chk("cold_stall", 32'(st), 32'd9);
    chk("cold_rdata", rd, 32'hC0DE_0100);
    chk("cold_nbeats", 32'(ack_addr.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < ack_addr.size())
        chk($sformatf("cold_beat%0d", i), ack_addr[base+i], 32'h100 + 32'(4 * i));
    chk("cold_miss", miss_count, 32'd1);
    chk("cold_hits", hit_count, 32'd0);

    base = ack_addr.size();
    access(1'b0, 32'h108, 32'h0, st, rd);
    chk("hit_stall", 32'(st), 32'd0);
    chk("hit_rdata", rd, 32'hC0DE_0108);
    chk("hit_hits", hit_count, 32'd1);
    chk("hit_no_mem", 32'(ack_addr.size() - base), 32'd0);

    // Conflict on index 0.
    base = ack_addr.size();
    access(1'b0, 32'h500, 32'h0, st, rd);
    chk("conf_stall", 32'(st), 32'd9);
    chk("conf_rdata", rd, 32'hC0DE_0500);
    if (ack_addr.size() > base) chk("conf_first_addr", ack_addr[base], 32'h500);
    else chk("conf_first_addr", 32'hFFFF_FFFF, 32'h500);
    access(1'b0, 32'h100, 32'h0, st, rd);
    chk("reload_stall", 32'(st), 32'd9);
    chk("reload_rdata", rd, 32'hC0DE_0100);
    chk("reload_miss", miss_count, 32'd3);

    // Stores with zero-wait memory.
    lat = 0;
    base = ack_addr.size();
    access(1'b1, 32'h104, 32'hDEAD_BEEF, st, rd);
    chk("st_hit_stall", 32'(st), 32'd1);
    chk("st_hit_nbeats", 32'(ack_addr.size() - base), 32'd1);
    if (ack_addr.size() > base) begin
      chk("st_hit_addr", ack_addr[base], 32'h104);
      chk("st_hit_we", 32'(ack_we[base]), 32'd1);
    end
    access(1'b0, 32'h104, 32'h0, st, rd);
    chk("ld_after_st_stall", 32'(st), 32'd0);
    chk("ld_after_st_rdata", rd, 32'hDEAD_BEEF);
    chk("ld_after_st_hits", hit_count, 32'd2);

    base = ack_addr.size();
    access(1'b1, 32'h900, 32'h1234_5678, st, rd);
    chk("st_miss_stall", 32'(st), 32'd1);
    chk("st_miss_nbeats", 32'(ack_addr.size() - base), 32'd1);
    access(1'b0, 32'h900, 32'h0, st, rd);
    chk("ld_900_stall", 32'(st), 32'd5);
    chk("ld_900_rdata", rd, 32'h1234_5678);
    chk("ld_900_miss", miss_count, 32'd4);
    chk("ld_900_hits", hit_count, 32'd2);

    // Idle window.
    base = ack_addr.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (!cache_ready || mem_req) chk($sformatf("idle_cyc%0d", i), {cache_ready, mem_req}, 32'd2);
    end
    chk("idle_ready", 32'(cache_ready), 32'd1);
    chk("idle_mem_req", 32'(mem_req), 32'd0);
    chk("idle_no_mem", 32'(ack_addr.size() - base), 32'd0);
    chk("idle_hits", hit_count, 32'd2);
    chk("idle_miss", miss_count, 32'd4);

    // Reset during beat 2 of a refill.
    lat = 1;
    base = ack_addr.size();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h100;
    guard = 0;
    #1;
    while (ack_addr.size() - base < 2 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("mid_guard", 32'(guard >= 100), 32'd0);
    @(posedge clk);
    #3;
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    chk("mid_mem_addr", mem_addr, 32'h108);
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_miss", miss_count, 32'd0);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    access(1'b0, 32'h100, 32'h0, st, rd);
    chk("post_rst_stall", 32'(st), 32'd9);
    chk("post_rst_rdata", rd, 32'hC0DE_0100);
    chk("post_rst_miss", miss_count, 32'd1);
    chk("post_rst_hits", hit_count, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
